// File: rtl/mpu_pkg.sv
// mpu_pkg: shared definitions for the MPU program sequencer.
//   ADDR_W      default program-address width
//   next_addr_e source selector for the next program-memory address
package mpu_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    NA_RESET,   // reset address while reset_n is low
    NA_POP,     // top of return stack (RET)
    NA_TARGET,  // jump / call destination
    NA_HOLD,    // repeat current pc (stall)
    NA_INC      // pc + 1, wrapping
  } next_addr_e;

endpackage

// File: rtl/lifo_stack.sv
// lifo_stack: small register-based LIFO used as the hardware return stack.
//   clk, reset_n  clock, async active-low reset (clears occupancy only)
//   push, din     write din on top; ignored when full
//   pop           discard top entry; ignored when empty
//   dout          current top entry (don't-care when empty)
//   count         occupancy 0..DEPTH
//   full, empty   count==DEPTH / count==0
module lifo_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [CW-1:0]               count_q, count_d;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Top entry lives at index count-1; a compare loop keeps index widths exact.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) + CW'(1) == count_q) dout = mem_q[i];
  end

  // A valid pop takes precedence over a push in the same cycle.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == count_q) mem_d[i] = din;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // Contents are don't-care after reset; only occupancy is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/call_stack_sequencer.sv
// call_stack_sequencer: MPU program sequencer producing the program-ROM
// address each cycle, with jump, jump-if-not-zero, CALL/RET on a hardware
// return stack, stall, and sticky stack-error flags.
//   clk, reset_n            clock, async active-low reset
//   stall                   hold pc
//   jmp, jmp_nz, zero_flag  unconditional / not-zero jump to target
//   call, ret, target       subroutine call (push pc+1) / return (pop)
//   err_clr                 clear sticky error flags
//   pm_addr                 combinational next address (to ROM)
//   pc                      registered current address
//   sp, stack_full/empty    return-stack occupancy
//   err_overflow/underflow  sticky CALL-when-full / RET-when-empty
module call_stack_sequencer
  import mpu_pkg::*;
#(
  parameter int                ADDR_W     = mpu_pkg::ADDR_W,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       jmp,
  input  logic                       jmp_nz,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       zero_flag,
  input  logic [ADDR_W-1:0]          target,
  input  logic                       err_clr,
  output logic [ADDR_W-1:0]          pm_addr,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, tos;
  logic              err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
  logic              push, pop, ovf_set, unf_set;
  next_addr_e        sel;

  // Natural ADDR_W-bit overflow gives the required modulo wrap.
  assign pc_inc = pc_q + ADDR_W'(1);

  lifo_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (pc_inc),
    .dout    (tos),
    .count   (sp),
    .full    (stack_full),
    .empty   (stack_empty)
  );

  // Priority select; ret beats call, and any control beats stall.
  always_comb begin
    sel     = NA_INC;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!reset_n) begin
      sel = NA_RESET;
    end else if (ret) begin
      if (!stack_empty) begin
        sel = NA_POP;
        pop = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end else if (call) begin
      if (!stack_full) begin
        sel  = NA_TARGET;
        push = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (jmp || (jmp_nz && !zero_flag)) begin
      sel = NA_TARGET;
    end else if (stall) begin
      sel = NA_HOLD;
    end
  end

  always_comb begin
    unique case (sel)
      NA_RESET:  pm_addr = RESET_ADDR;
      NA_POP:    pm_addr = tos;
      NA_TARGET: pm_addr = target;
      NA_HOLD:   pm_addr = pc_q;
      NA_INC:    pm_addr = pc_inc;
      default:   pm_addr = pc_inc;
    endcase
  end

  // A new error in the clearing cycle keeps the flag set.
  always_comb begin
    pc_d      = pm_addr;
    err_ovf_d = ovf_set | (err_ovf_q & ~err_clr);
    err_unf_d = unf_set | (err_unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_ADDR;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign pc            = pc_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule
